imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time writer for the pipeline's word-addressed instruction memory. Accepts a byte stream over a valid/ready handshake. Parses a word-count header, assembles big-endian 32-bit instructions and issues one write per word from `BASE_ADDR` upward, then checks a trailing additive checksum. Holds the CPU in stall (`cpu_hold`) until a load completes cleanly. Sits between the host/debug byte source and the write port of the instruction memory.

## Interface
- `ADDR_W`, 9, memory word-address width; depth is 2^ADDR_W = 512 words.
- `BASE_ADDR`, 0, word address of the first instruction written.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle load request.
- `in_valid` in 1: byte source has data.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader accepts a byte this cycle.
- `mem_wen` out 1: instruction-memory write enable, one cycle per word.
- `mem_addr` out ADDR_W: write word address.
- `mem_wdata` out 32: instruction word.
- `cpu_hold` out 1: stall request to the pipeline.
- `done` out 1: sticky, load finished and checksum matched.
- `error` out 1: sticky, length overflow or checksum mismatch.
- `word_count` out ADDR_W+1: words written in the current or last load.

## Operation
- A byte is accepted on a rising edge with `in_valid && in_ready`.
- Stream format:
  - LEN_HI and LEN_LO give N, a 16-bit word count.
  - Then N×4 data bytes, most significant byte first (the first byte is bits 31:24).
  - Then one checksum byte equal to the sum mod 256 of all data bytes. Length bytes are excluded.
- States and transitions:
  - IDLE → LEN_HI on `start`.
  - LEN_HI → LEN_LO on a byte.
  - LEN_LO on a byte:
    - N > 2^ADDR_W: → ERROR.
    - N == 0: → CSUM.
    - Otherwise: → DATA.
  - DATA: a 2-bit byte counter advances per byte. On the 4th byte, the word is latched and a write is issued. After the N-th word, → CSUM.
  - CSUM on a byte: match → DONE, otherwise → ERROR.
  - DONE and ERROR are terminal until `start` or `reset`.
- `start` handling:
  - Honoured only in IDLE, DONE or ERROR. It clears `done`, `error`, `word_count`, the checksum accumulator and the byte counter, then enters LEN_HI.
  - Ignored in LEN_HI, LEN_LO, DATA and CSUM.
- `in_ready` is 1 exactly in LEN_HI, LEN_LO, DATA and CSUM. There is no backpressure inside an active load.
- Write addressing and counting:
  - The k-th word (k from 0) is written to `mem_addr` = BASE_ADDR + k, truncated to ADDR_W bits.
  - N ≤ 2^ADDR_W is enforced, so addresses never repeat within one load.
  - `word_count` increments with each `mem_wen` pulse.
- Checksum accumulator: 8 bits, wraps silently.
- `cpu_hold` = 1 in every state except DONE.
- Memory contents are never cleared by this block. An ERROR leaves any already-written words in place.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, `word_count`=0. State = IDLE.
- Reset asserted mid-load: every output and every internal counter returns to its reset value immediately.
- Write latency:
  - `mem_wen` is high for exactly the one cycle following the edge that accepted the 4th byte of a word.
  - `mem_addr` and `mem_wdata` are valid in that same cycle.
  - Between writes, `mem_addr` and `mem_wdata` hold their last values.
- A new byte may be accepted on the same edge that ends a `mem_wen` cycle. Back-to-back streaming sustains one word per 4 cycles.
- The last word's write completes no later than the edge that accepts the checksum byte.
- `done`, `error` and `cpu_hold` update on the edge after the deciding byte is accepted.
- `start` and `in_valid` high in the same IDLE cycle: the byte is not consumed, because `in_ready` is 0 in IDLE.
- Gaps in `in_valid` (`in_valid`=0) stall the parser with no state change.

## Test plan
- Reset check: hold `reset`=0 with random inputs, then release → all outputs at their reset values and `in_ready`=0 until `start`.
- Nominal load:
  - Stimulus: `start`, then bytes 00 02 | 20 08 00 05 | 01 09 50 20 | A7.
  - Required: `mem_wen` pulses writing 0x20080005 at address 0 and 0x01095020 at address 1.
  - Required: then `done`=1, `cpu_hold`=0, `word_count`=2.
- Bad checksum: same stream with a final byte of A6 → both writes still occur, `error`=1, `done`=0, `cpu_hold`=1.
- Length overflow: bytes 02 01 (N=513) → `error`=1 on the edge after LEN_LO, no `mem_wen`, `in_ready`=0.
- Empty load and gappy stream:
  - N=0 with checksum 00 → `done`=1, no writes.
  - Nominal stream with random 0–3 cycle `in_valid` gaps → identical writes and result.
- Reset and restart:
  - Stimulus: reset asserted after the first word's write in a 3-word load.
  - Required: outputs return to reset values.
  - Stimulus: a new `start` with a 1-word load (N=1, word 0xAC0A0000, checksum B6).
  - Required: writes address 0, `done`=1, `word_count`=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time byte-stream loader for the instruction memory.
// Parses length, assembles big-endian words, writes them, checks checksum.
module imem_loader #(
   parameter int ADDR_W    = 9,
   parameter int BASE_ADDR = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LENHI,
      S_LENLO,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [16:0]     MAX_N   = 17'(1) << ADDR_W;
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [7:0]          len_hi_q, len_hi_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [1:0]          bcnt_q, bcnt_d;
   logic [23:0]         shift_q, shift_d;
   logic [7:0]          csum_q, csum_d;
   logic [ADDR_W:0]     wc_q, wc_d;
   logic                rdy_q, rdy_d;
   logic                wen_q, wen_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                hold_q, hold_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic                acc;
   logic                start_ok;
   logic [15:0]         len_in;
   logic [ADDR_W:0]     wc_inc;
   logic                last_word;

   assign acc       = in_valid && rdy_q;
   assign start_ok  = start && (state_q == S_IDLE ||
                                state_q == S_DONE ||
                                state_q == S_ERR);
   assign len_in    = {len_hi_q, in_data};
   assign wc_inc    = wc_q + CNT_ONE;
   assign last_word = (wc_inc == len_q);

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode of the stream parser
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) state_d = S_LENHI;
         end
         S_LENHI: begin
            if (acc) state_d = S_LENLO;
         end
         S_LENLO: begin
            if (acc) begin
               if ({1'b0, len_in} > MAX_N) state_d = S_ERR;
               else if (len_in == 16'd0)   state_d = S_CSUM;
               else                        state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (acc && bcnt_q == 2'd3 && last_word)
               state_d = S_CSUM;
         end
         S_CSUM: begin
            if (acc)
               state_d = (in_data == csum_q) ? S_DONE : S_ERR;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output and datapath next values; outputs follow the next state
   always_comb begin
      len_hi_d = len_hi_q;
      len_d    = len_q;
      bcnt_d   = bcnt_q;
      shift_d  = shift_q;
      csum_d   = csum_q;
      wc_d     = wc_q;
      wen_d    = 1'b0;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      if (start_ok) begin
         wc_d   = '0;
         csum_d = '0;
         bcnt_d = '0;
      end else if (acc) begin
         unique case (state_q)
            S_LENHI: len_hi_d = in_data;
            S_LENLO: len_d    = len_in[ADDR_W:0];
            S_DATA: begin
               bcnt_d  = bcnt_q + 2'd1;
               csum_d  = csum_q + in_data;
               shift_d = {shift_q[15:0], in_data};
               if (bcnt_q == 2'd3) begin
                  wen_d   = 1'b1;
                  addr_d  = ADDR_W'(BASE_ADDR) + wc_q[ADDR_W-1:0];
                  wdata_d = {shift_q, in_data};
                  wc_d    = wc_inc;
               end
            end
            default: ;
         endcase
      end
      rdy_d  = (state_d == S_LENHI) || (state_d == S_LENLO) ||
               (state_d == S_DATA)  || (state_d == S_CSUM);
      hold_d = (state_d != S_DONE);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERR);
   end

   // Datapath and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         len_hi_q <= '0;
         len_q    <= '0;
         bcnt_q   <= '0;
         shift_q  <= '0;
         csum_q   <= '0;
         wc_q     <= '0;
         rdy_q    <= 1'b0;
         wen_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         hold_q   <= 1'b1;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         len_hi_q <= len_hi_d;
         len_q    <= len_d;
         bcnt_q   <= bcnt_d;
         shift_q  <= shift_d;
         csum_q   <= csum_d;
         wc_q     <= wc_d;
         rdy_q    <= rdy_d;
         wen_q    <= wen_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         hold_q   <= hold_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign in_ready   = rdy_q;
   assign mem_wen    = wen_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign cpu_hold   = hold_q;
   assign done       = done_q;
   assign error      = err_q;
   assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads checked
// against a stream-level reference model.
module tb_imem_loader;

   localparam int ADDR_W = 9;
   localparam int BASE   = 0;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
      .clock(clock), .reset(reset), .start(start),
      .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_wen(mem_wen),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error),
      .word_count(word_count)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   logic [7:0]  stream[$];
   int          exp_a[$];
   logic [31:0] exp_d[$];
   bit          exp_done, exp_err;
   int          got_a[$];
   logic [31:0] got_d[$];

   always @(negedge clock)
      if (reset === 1'b1 && mem_wen === 1'b1) begin
         got_a.push_back(int'(mem_addr));
         got_d.push_back(mem_wdata);
      end

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: interpret the byte stream from the format rules.
   task automatic model();
      int n, sum;
      logic [31:0] w;
      exp_a.delete();
      exp_d.delete();
      n = (int'(stream[0]) << 8) | int'(stream[1]);
      if (n > DEPTH) begin
         exp_done = 0;
         exp_err  = 1;
         return;
      end
      sum = 0;
      for (int k = 0; k < n; k++) begin
         w = {stream[2+4*k], stream[3+4*k],
              stream[4+4*k], stream[5+4*k]};
         for (int j = 0; j < 4; j++)
            sum += int'(stream[2+4*k+j]);
         exp_a.push_back((BASE + k) % DEPTH);
         exp_d.push_back(w);
      end
      exp_done = (int'(stream[2+4*n]) == (sum % 256));
      exp_err  = !exp_done;
   endtask

   task automatic build(input int n, input bit bad);
      int sum;
      logic [31:0] w;
      stream.delete();
      stream.push_back(8'(n >> 8));
      stream.push_back(8'(n));
      sum = 0;
      for (int k = 0; k < n; k++) begin
         w = $urandom;
         for (int j = 3; j >= 0; j--) begin
            stream.push_back(w[8*j +: 8]);
            sum += int'(w[8*j +: 8]);
         end
      end
      stream.push_back(8'(sum + (bad ? 1 + $urandom_range(0, 254) : 0)));
   endtask

   task automatic send(input bit gappy);
      int g, cnt;
      foreach (stream[i]) begin
         if (gappy) begin
            g = $urandom_range(0, 3);
            repeat (g) @(negedge clock);
         end
         in_valid = 1'b1;
         in_data  = stream[i];
         cnt = 0;
         while (!in_ready && cnt < 20) begin
            @(negedge clock);
            cnt++;
         end
         if (!in_ready) begin
            tests++;
            fails++;
            $error("FAIL in_ready timeout: got 0 expected 1 at byte %0d", i);
            in_valid = 1'b0;
            return;
         end
         @(negedge clock);
         in_valid = 1'b0;
      end
   endtask

   task automatic run_load(input string tag, input bit gappy);
      model();
      got_a.delete();
      got_d.delete();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check({tag, "/wc_clr"}, 64'(word_count), 0);
      check({tag, "/done_clr"}, 64'(done), 0);
      check({tag, "/hold"}, 64'(cpu_hold), 1);
      send(gappy);
      repeat (3) @(negedge clock);
      check({tag, "/done"}, 64'(done), 64'(exp_done));
      check({tag, "/error"}, 64'(error), 64'(exp_err));
      check({tag, "/cpu_hold"}, 64'(cpu_hold), 64'(!exp_done));
      check({tag, "/in_ready"}, 64'(in_ready), 0);
      check({tag, "/wcount"}, 64'(word_count), 64'(exp_a.size()));
      check({tag, "/nwrites"}, 64'(got_a.size()), 64'(exp_a.size()));
      if (got_a.size() == exp_a.size())
         foreach (exp_a[i]) begin
            check({tag, "/addr"}, 64'(got_a[i]), 64'(exp_a[i]));
            check({tag, "/data"}, 64'(got_d[i]), 64'(exp_d[i]));
         end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "/in_ready"}, 64'(in_ready), 0);
      check({tag, "/mem_wen"}, 64'(mem_wen), 0);
      check({tag, "/mem_addr"}, 64'(mem_addr), 0);
      check({tag, "/mem_wdata"}, 64'(mem_wdata), 0);
      check({tag, "/cpu_hold"}, 64'(cpu_hold), 1);
      check({tag, "/done"}, 64'(done), 0);
      check({tag, "/error"}, 64'(error), 0);
      check({tag, "/wcount"}, 64'(word_count), 0);
   endtask

   logic [31:0] w0;

   initial begin
      // Reset with random inputs
      repeat (5) begin
         @(negedge clock);
         start    = 1'($urandom);
         in_valid = 1'($urandom);
         in_data  = 8'($urandom);
      end
      check_reset_vals("rst_hold");
      @(negedge clock);
      start = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_reset_vals("rst_rel");
      in_valid = 1'b0;

      // Nominal load
      stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h01, 8'h09, 8'h50, 8'h20, 8'hA7};
      run_load("nominal", 1'b0);
      check("nominal/w0", 64'(exp_d[0]), 64'h20080005);

      // Bad checksum
      stream[10] = 8'hA6;
      run_load("badsum", 1'b0);

      // Length overflow
      stream = '{8'h02, 8'h01};
      run_load("overflow", 1'b0);

      // Empty load
      stream = '{8'h00, 8'h00, 8'h00};
      run_load("empty", 1'b0);

      // Gappy nominal
      stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h01, 8'h09, 8'h50, 8'h20, 8'hA7};
      run_load("gappy", 1'b1);

      // Randomized loads
      for (int r = 0; r < 6; r++) begin
         build($urandom_range(1, 6), $urandom_range(0, 3) == 0);
         run_load("rand", 1'b1);
      end

      // Full-depth load, last address 511
      build(DEPTH, 1'b0);
      run_load("full", 1'b0);

      // Reset after the first write of a 3-word load
      w0 = $urandom | 32'h1;
      stream = '{8'h00, 8'h03, w0[31:24], w0[23:16],
                 w0[15:8], w0[7:0]};
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      send(1'b0);
      check("mid/wen", 64'(mem_wen), 1);
      check("mid/wdata", 64'(mem_wdata), 64'(w0));
      check("mid/wcount", 64'(word_count), 1);
      reset = 1'b0;
      #1;
      check_reset_vals("mid_rst");
      @(negedge clock);
      reset = 1'b1;

      // Restart with a 1-word load
      stream = '{8'h00, 8'h01, 8'hAC, 8'h0A, 8'h00,
                 8'h00, 8'hB6};
      run_load("restart", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
